// File: rtl/bcd_conv_arbiter.sv
// ============================================================================
//  Module   : bcd_conv_arbiter
//  Brief    : Two-requester round-robin front end for a one-bit-per-clock
//             double-dabble binary-to-BCD converter with 9999 saturation.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_conv_arbiter #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic [BIN_W-1:0]      bin0,
    input  logic                  req1,
    input  logic [BIN_W-1:0]      bin1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    function automatic logic [31:0] f_pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p;
    endfunction

    localparam int                  c_BCD_W    = 4 * DIGITS;
    localparam int                  c_CNT_W    = $clog2(BIN_W + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(BIN_W - 1);
    localparam logic [31:0]         c_MAX_VAL  = f_pow10(DIGITS) - 32'd1;
    localparam logic [c_BCD_W-1:0]  c_SAT_BCD  = {DIGITS{4'h9}};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [BIN_W-1:0]     r_op;
    logic [c_BCD_W-1:0]   r_work;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_src;
    logic                 r_ovf_pend;
    logic                 r_last;

    logic                 w_start;
    logic                 w_win_id;
    logic [BIN_W-1:0]     w_sel_bin;
    logic                 w_sel_ovf;
    logic                 w_last;
    logic [c_BCD_W-1:0]   w_work_adj;
    logic [c_BCD_W-1:0]   w_work_shift;

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        w_win_id = 1'b0;
        if (req0 && req1) begin
            w_win_id = ~r_last;
        end else if (req1) begin
            w_win_id = 1'b1;
        end
    end

    assign w_start   = (r_state == S_IDLE) && (req0 || req1);
    assign w_sel_bin = w_win_id ? bin1 : bin0;
    assign w_sel_ovf = ({{(32-BIN_W){1'b0}}, w_sel_bin} > c_MAX_VAL);
    assign w_last    = (r_cnt == c_CNT_LAST);

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        logic [3:0] w_dig;
        assign w_dig = r_work[4*d +: 4];
        assign w_work_adj[4*d +: 4] = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
    end

    // The top adjusted bit falls off the left; operand MSB enters at bit 0.
    assign w_work_shift = (w_work_adj << 1) | {{(c_BCD_W-1){1'b0}}, r_op[BIN_W-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_src      <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_last     <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            bcd        <= '0;
            ovf        <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            if (w_start) begin
                r_op       <= w_sel_bin;
                r_work     <= '0;
                r_cnt      <= '0;
                r_src      <= w_win_id;
                r_ovf_pend <= w_sel_ovf;
                r_last     <= w_win_id;
                gnt0       <= ~w_win_id;
                gnt1       <= w_win_id;
            end else if (r_state == S_SHIFT) begin
                r_work <= w_work_shift;
                r_op   <= r_op << 1;
                r_cnt  <= r_cnt + 1'b1;
                if (w_last) begin
                    bcd     <= r_ovf_pend ? c_SAT_BCD : w_work_shift;
                    ovf     <= r_ovf_pend;
                    done_id <= r_src;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
// ============================================================================
//  Module   : tb_bcd_conv_arbiter
//  Brief    : Directed self-checking bench for bcd_conv_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_conv_arbiter;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int c_BOUND = 60;

    logic              clk;
    logic              rst_n;
    logic              req0;
    logic [BIN_W-1:0]  bin0;
    logic              req1;
    logic [BIN_W-1:0]  bin1;
    logic              gnt0;
    logic              gnt1;
    logic              busy;
    logic              done;
    logic              done_id;
    logic [15:0]       bcd;
    logic              ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int n_gnt1  = 0;
    int n_done  = 0;

    bcd_conv_arbiter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .bin0    (bin0),
        .req1    (req1),
        .bin1    (bin1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .bcd     (bcd),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gnt1) n_gnt1 <= n_gnt1 + 1;
        if (done) n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
    endfunction

    task automatic wait_gnt(output int cycles, output logic which);
        cycles = 0;
        while (!(gnt0 || gnt1) && cycles < c_BOUND) begin
            @(negedge clk);
            cycles++;
        end
        if (!(gnt0 || gnt1)) check("gnt_timeout", 32'd0, 32'd1);
        which = gnt1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < c_BOUND) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic convert1(input string tag, input int v, input logic [15:0] eb, input logic eo);
        int   c;
        logic w;
        req1 = 1'b1;
        bin1 = BIN_W'(v);
        wait_gnt(c, w);
        check({tag, "_gnt_id"}, 32'(w), 32'd1);
        req1 = 1'b0;
        wait_done(c);
        check({tag, "_lat"}, 32'(c), 32'd14);
        check({tag, "_bcd"}, 32'(bcd), 32'(eb));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        check({tag, "_id"}, 32'(done_id), 32'd1);
    endtask

    initial begin
        int   c;
        logic w;
        int   g1;
        int   d0;
        int   vals[$];

        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        bin0  = '0;
        bin1  = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic conversion on requester 0
        req0 = 1'b1;
        bin0 = 14'd1234;
        wait_gnt(c, w);
        check("basic_gnt_id", 32'(w), 32'd0);
        check("basic_gnt0", 32'(gnt0), 32'd1);
        check("basic_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        @(negedge clk);
        check("basic_gnt0_fall", 32'(gnt0), 32'd0);
        wait_done(c);
        check("basic_lat", 32'(c + 1), 32'd14);
        check("basic_bcd", 32'(bcd), 32'h1234);
        check("basic_ovf", 32'(ovf), 32'd0);
        check("basic_id", 32'(done_id), 32'd0);
        check("basic_busy_fall", 32'(busy), 32'd0);
        @(negedge clk);
        check("basic_done_fall", 32'(done), 32'd0);
        check("basic_bcd_hold", 32'(bcd), 32'h1234);

        convert1("b0", 0, 16'h0000, 1'b0);
        convert1("b9999", 9999, 16'h9999, 1'b0);
        convert1("b10000", 10000, 16'h9999, 1'b1);
        convert1("b16383", 16383, 16'h9999, 1'b1);

        // Contention: last grant was req1, so req0 wins first
        req0 = 1'b1;
        req1 = 1'b1;
        bin0 = 14'd42;
        bin1 = 14'd7;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(c, w);
            check("cont_gnt_id", 32'(w), 32'(k % 2));
            if (k > 0) check("cont_gap", 32'(c), 32'd1);
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            wait_done(c);
            check("cont_lat", 32'(c), 32'd14);
            check("cont_id", 32'(done_id), 32'(k % 2));
            check("cont_bcd", 32'(bcd), (k % 2 == 1) ? 32'h0007 : 32'h0042);
        end

        // Request from requester 1 while busy must be ignored
        req0 = 1'b1;
        bin0 = 14'd500;
        wait_gnt(c, w);
        check("busy_gnt_id", 32'(w), 32'd0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        g1 = n_gnt1;
        d0 = n_done;
        repeat (3) @(negedge clk);
        req1 = 1'b1;
        bin1 = 14'd77;
        @(negedge clk);
        req1 = 1'b0;
        wait_done(c);
        check("busy_lat", 32'(c), 32'd8);
        check("busy_id", 32'(done_id), 32'd0);
        check("busy_bcd", 32'(bcd), 32'h0500);
        repeat (20) @(negedge clk);
        check("busy_no_gnt1", 32'(n_gnt1), 32'(g1));
        check("busy_one_done", 32'(n_done), 32'(d0 + 1));

        // Reset in the middle of a conversion
        d0 = n_done;
        req0 = 1'b1;
        bin0 = 14'd4321;
        wait_gnt(c, w);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bcd", 32'(bcd), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        req1 = 1'b1;
        bin1 = 14'd305;
        repeat (12) @(negedge clk);
        check("mid_rst_no_done", 32'(n_done), 32'(d0));
        rst_n = 1'b1;
        wait_gnt(c, w);
        check("post_rst_gnt_id", 32'(w), 32'd1);
        req1 = 1'b0;
        wait_done(c);
        check("post_rst_bcd", 32'(bcd), 32'h0305);
        check("post_rst_id", 32'(done_id), 32'd1);
        check("post_rst_ovf", 32'(ovf), 32'd0);
        repeat (3) @(negedge clk);
        check("post_rst_done_cnt", 32'(n_done), 32'(d0 + 1));

        // Back-to-back sweep over a sampled operand range plus edge values
        for (int v = 0; v < 16384; v += 131) vals.push_back(v);
        vals.push_back(1);
        vals.push_back(9);
        vals.push_back(10);
        vals.push_back(99);
        vals.push_back(100);
        vals.push_back(999);
        vals.push_back(1000);
        vals.push_back(9998);
        vals.push_back(9999);
        vals.push_back(10000);
        vals.push_back(10001);
        vals.push_back(16383);
        req0 = 1'b1;
        bin0 = BIN_W'(vals[0]);
        for (int i = 0; i < vals.size(); i++) begin
            wait_gnt(c, w);
            if (i > 0) check("sweep_gap", 32'(c), 32'd1);
            if (i + 1 < vals.size()) bin0 = BIN_W'(vals[i + 1]);
            else req0 = 1'b0;
            wait_done(c);
            check("sweep_bcd", 32'(bcd), 32'(exp_bcd(vals[i])));
            check("sweep_ovf", 32'(ovf), (vals[i] > 9999) ? 32'd1 : 32'd0);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
